// File: rtl/alu_op_issuer.sv
// Issues one RV32I integer/branch instruction to an external combinational ALU:
// decode and register operands, let the ALU settle for a cycle, then hold the result until taken.
module alu_op_issuer #(
    parameter int DATA_WIDTH  = 32,
    parameter int INSTR_WIDTH = 32,
    parameter int CTRL_BITS   = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   instr_valid,
    output logic                   instr_ready,
    input  logic [INSTR_WIDTH-1:0] instr,
    input  logic [DATA_WIDTH-1:0]  pc,
    input  logic [DATA_WIDTH-1:0]  rs1_data,
    input  logic [DATA_WIDTH-1:0]  rs2_data,
    output logic [CTRL_BITS-1:0]   alu_ctrl,
    output logic [DATA_WIDTH-1:0]  alu_a,
    output logic [DATA_WIDTH-1:0]  alu_b,
    input  logic [DATA_WIDTH-1:0]  alu_c,
    input  logic                   alu_zero,
    input  logic                   alu_over,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [DATA_WIDTH-1:0]  res_data,
    output logic [4:0]             res_rd,
    output logic                   res_we,
    output logic                   res_over,
    output logic                   res_br_taken,
    output logic [DATA_WIDTH-1:0]  res_br_target,
    output logic                   res_illegal
);

    localparam logic [CTRL_BITS-1:0] CTRL_AND = CTRL_BITS'(4'b0000);
    localparam logic [CTRL_BITS-1:0] CTRL_OR  = CTRL_BITS'(4'b0001);
    localparam logic [CTRL_BITS-1:0] CTRL_ADD = CTRL_BITS'(4'b0010);
    localparam logic [CTRL_BITS-1:0] CTRL_SUB = CTRL_BITS'(4'b0110);
    localparam logic [CTRL_BITS-1:0] CTRL_SLT = CTRL_BITS'(4'b0111);
    localparam logic [CTRL_BITS-1:0] CTRL_SGE = CTRL_BITS'(4'b0101);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [DATA_WIDTH-1:0] MSB_BIT = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;
    typedef enum logic [1:0] {BR_NONE, BR_EQ, BR_NE, BR_C0} br_kind_t;

    function automatic logic [DATA_WIDTH-1:0] sext(input logic signed [31:0] v);
        return DATA_WIDTH'(v);
    endfunction

    // Flipping the sign bit turns an unsigned compare into a signed one.
    function automatic logic [DATA_WIDTH-1:0] bias(input logic [DATA_WIDTH-1:0] v);
        return v ^ MSB_BIT;
    endfunction

    logic [6:0]         opcode;
    logic [2:0]         funct3;
    logic [6:0]         funct7;
    logic [4:0]         rd_field;
    logic signed [31:0] i_imm;
    logic signed [31:0] u_imm;
    logic signed [31:0] b_imm;

    assign opcode   = instr[6:0];
    assign rd_field = instr[11:7];
    assign funct3   = instr[14:12];
    assign funct7   = instr[31:25];
    assign i_imm    = {{20{instr[31]}}, instr[31:20]};
    assign u_imm    = {instr[31:12], 12'b0};
    assign b_imm    = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};

    logic [CTRL_BITS-1:0]  dec_ctrl;
    logic [DATA_WIDTH-1:0] dec_a;
    logic [DATA_WIDTH-1:0] dec_b;
    logic                  dec_wb;
    logic                  dec_over_en;
    br_kind_t              dec_br;
    logic                  dec_illegal;
    logic [4:0]            dec_rd;
    logic [DATA_WIDTH-1:0] dec_target;

    always_comb begin
        dec_ctrl    = CTRL_AND;
        dec_a       = '0;
        dec_b       = '0;
        dec_wb      = 1'b0;
        dec_over_en = 1'b0;
        dec_br      = BR_NONE;
        dec_illegal = 1'b0;
        case (opcode)
            OPC_OP, OPC_OP_IMM: begin
                dec_a  = rs1_data;
                dec_b  = (opcode == OPC_OP) ? rs2_data : sext(i_imm);
                dec_wb = 1'b1;
                if (opcode == OPC_OP && funct7 == 7'b0100000 && funct3 == 3'b000) begin
                    dec_ctrl    = CTRL_SUB;
                    dec_over_en = 1'b1;
                end else if (opcode == OPC_OP && funct7 != 7'b0000000) begin
                    dec_illegal = 1'b1;
                end else begin
                    case (funct3)
                        3'b000: begin
                            dec_ctrl    = CTRL_ADD;
                            dec_over_en = 1'b1;
                        end
                        3'b111: dec_ctrl = CTRL_AND;
                        3'b110: dec_ctrl = CTRL_OR;
                        3'b011: dec_ctrl = CTRL_SLT;
                        3'b010: begin
                            dec_ctrl = CTRL_SLT;
                            dec_a    = bias(dec_a);
                            dec_b    = bias(dec_b);
                        end
                        default: dec_illegal = 1'b1;
                    endcase
                end
            end
            OPC_LUI: begin
                dec_ctrl = CTRL_ADD;
                dec_b    = sext(u_imm);
                dec_wb   = 1'b1;
            end
            OPC_AUIPC: begin
                dec_ctrl = CTRL_ADD;
                dec_a    = pc;
                dec_b    = sext(u_imm);
                dec_wb   = 1'b1;
            end
            OPC_BRANCH: begin
                dec_a = rs1_data;
                dec_b = rs2_data;
                case (funct3)
                    3'b000: begin
                        dec_ctrl = CTRL_SUB;
                        dec_br   = BR_EQ;
                    end
                    3'b001: begin
                        dec_ctrl = CTRL_SUB;
                        dec_br   = BR_NE;
                    end
                    3'b100: begin
                        dec_ctrl = CTRL_SLT;
                        dec_br   = BR_C0;
                        dec_a    = bias(rs1_data);
                        dec_b    = bias(rs2_data);
                    end
                    3'b101: begin
                        dec_ctrl = CTRL_SGE;
                        dec_br   = BR_C0;
                        dec_a    = bias(rs1_data);
                        dec_b    = bias(rs2_data);
                    end
                    3'b110: begin
                        dec_ctrl = CTRL_SLT;
                        dec_br   = BR_C0;
                    end
                    3'b111: begin
                        dec_ctrl = CTRL_SGE;
                        dec_br   = BR_C0;
                    end
                    default: dec_illegal = 1'b1;
                endcase
            end
            default: dec_illegal = 1'b1;
        endcase

        // Illegal instructions present a quiet, all-zero request to the ALU.
        if (dec_illegal) begin
            dec_ctrl    = CTRL_AND;
            dec_a       = '0;
            dec_b       = '0;
            dec_wb      = 1'b0;
            dec_over_en = 1'b0;
            dec_br      = BR_NONE;
        end

        dec_rd     = dec_wb ? rd_field : 5'd0;
        dec_target = (dec_br != BR_NONE) ? (pc + sext(b_imm)) : '0;
    end

    state_t                state_q, state_d;
    logic [CTRL_BITS-1:0]  alu_ctrl_q, alu_ctrl_d;
    logic [DATA_WIDTH-1:0] alu_a_q, alu_a_d;
    logic [DATA_WIDTH-1:0] alu_b_q, alu_b_d;
    logic                  wb_q, wb_d;
    logic                  over_en_q, over_en_d;
    br_kind_t              br_q, br_d;
    logic                  illegal_q, illegal_d;
    logic [4:0]            rd_q, rd_d;
    logic [DATA_WIDTH-1:0] target_q, target_d;

    logic [DATA_WIDTH-1:0] res_data_q, res_data_d;
    logic [4:0]            res_rd_q, res_rd_d;
    logic                  res_we_q, res_we_d;
    logic                  res_over_q, res_over_d;
    logic                  res_br_taken_q, res_br_taken_d;
    logic [DATA_WIDTH-1:0] res_br_target_q, res_br_target_d;
    logic                  res_illegal_q, res_illegal_d;

    always_comb begin
        state_d         = state_q;
        alu_ctrl_d      = alu_ctrl_q;
        alu_a_d         = alu_a_q;
        alu_b_d         = alu_b_q;
        wb_d            = wb_q;
        over_en_d       = over_en_q;
        br_d            = br_q;
        illegal_d       = illegal_q;
        rd_d            = rd_q;
        target_d        = target_q;
        res_data_d      = res_data_q;
        res_rd_d        = res_rd_q;
        res_we_d        = res_we_q;
        res_over_d      = res_over_q;
        res_br_taken_d  = res_br_taken_q;
        res_br_target_d = res_br_target_q;
        res_illegal_d   = res_illegal_q;
        case (state_q)
            S_IDLE: begin
                if (instr_valid) begin
                    state_d    = S_EXEC;
                    alu_ctrl_d = dec_ctrl;
                    alu_a_d    = dec_a;
                    alu_b_d    = dec_b;
                    wb_d       = dec_wb;
                    over_en_d  = dec_over_en;
                    br_d       = dec_br;
                    illegal_d  = dec_illegal;
                    rd_d       = dec_rd;
                    target_d   = dec_target;
                end
            end
            S_EXEC: begin
                // ALU outputs have had a full cycle to settle on the registered operands.
                state_d         = S_RESP;
                res_data_d      = wb_q ? alu_c : '0;
                res_rd_d        = rd_q;
                res_we_d        = wb_q && (rd_q != 5'd0);
                res_over_d      = over_en_q && alu_over;
                res_br_target_d = target_q;
                res_illegal_d   = illegal_q;
                case (br_q)
                    BR_EQ:   res_br_taken_d = alu_zero;
                    BR_NE:   res_br_taken_d = !alu_zero;
                    BR_C0:   res_br_taken_d = alu_c[0];
                    default: res_br_taken_d = 1'b0;
                endcase
            end
            S_RESP: begin
                if (res_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= S_IDLE;
            alu_ctrl_q      <= '0;
            alu_a_q         <= '0;
            alu_b_q         <= '0;
            wb_q            <= 1'b0;
            over_en_q       <= 1'b0;
            br_q            <= BR_NONE;
            illegal_q       <= 1'b0;
            rd_q            <= '0;
            target_q        <= '0;
            res_data_q      <= '0;
            res_rd_q        <= '0;
            res_we_q        <= 1'b0;
            res_over_q      <= 1'b0;
            res_br_taken_q  <= 1'b0;
            res_br_target_q <= '0;
            res_illegal_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            alu_ctrl_q      <= alu_ctrl_d;
            alu_a_q         <= alu_a_d;
            alu_b_q         <= alu_b_d;
            wb_q            <= wb_d;
            over_en_q       <= over_en_d;
            br_q            <= br_d;
            illegal_q       <= illegal_d;
            rd_q            <= rd_d;
            target_q        <= target_d;
            res_data_q      <= res_data_d;
            res_rd_q        <= res_rd_d;
            res_we_q        <= res_we_d;
            res_over_q      <= res_over_d;
            res_br_taken_q  <= res_br_taken_d;
            res_br_target_q <= res_br_target_d;
            res_illegal_q   <= res_illegal_d;
        end
    end

    assign instr_ready   = (state_q == S_IDLE);
    assign res_valid     = (state_q == S_RESP);
    assign alu_ctrl      = alu_ctrl_q;
    assign alu_a         = alu_a_q;
    assign alu_b         = alu_b_q;
    assign res_data      = res_data_q;
    assign res_rd        = res_rd_q;
    assign res_we        = res_we_q;
    assign res_over      = res_over_q;
    assign res_br_taken  = res_br_taken_q;
    assign res_br_target = res_br_target_q;
    assign res_illegal   = res_illegal_q;

endmodule
